// File: rtl/led_chain_manchester_encoder.sv
// led_chain_manchester_encoder
//   Re-encodes forwarded decoded bits as Manchester symbols for the next LED in the chain.
//   A DEPTH-entry bit FIFO absorbs the decoder's bursty strobes. Each popped bit becomes
//   one symbol of 2H cycles, where H = max(half_period, 2) is latched at pop time.
//   Encoding: bit 0 = high half then low half; bit 1 = low half then high half; idle = 0.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous reset, ACTIVE HIGH (1 = reset) despite the name
//   in_data      decoded bit, valid while in_clk = 1
//   in_clk       one-cycle bit strobe from the decoder
//   in_forward   enqueue qualifier (push = in_clk & in_forward)
//   in_swap      invert the enqueued bit
//   half_period  cycles per half-symbol, clamped to a minimum of 2
//   out          registered Manchester line
//   busy         symbol in progress or FIFO non-empty
//   fill         FIFO occupancy
//   overflow     sticky: a bit was dropped on a full FIFO
module led_chain_manchester_encoder #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_data,
  input  logic                     in_clk,
  input  logic                     in_forward,
  input  logic                     in_swap,
  input  logic [5:0]               half_period,
  output logic                     out,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FillMax = (PtrW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StFirst, StSecond} state_e;

  state_e              state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [5:0]          h_q, h_d;
  logic                bit_q, bit_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]       fill_q, fill_d;
  logic                ovf_q, ovf_d;
  logic [DEPTH-1:0]    mem_q;

  logic                push, push_bit, full, pop, wr_en;
  logic [5:0]          h_new;

  always_comb begin
    push     = in_clk & in_forward;
    push_bit = in_data ^ in_swap;
    full     = (fill_q == FillMax);
    h_new    = (half_period < 6'd2) ? 6'd2 : half_period;
  end

  // Symbol FSM: pops happen from IDLE or at the last SECOND cycle so symbols abut.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    h_d     = h_q;
    bit_d   = bit_q;
    pop     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (fill_q != '0) pop = 1'b1;
      end
      StFirst: begin
        if (cnt_q == 6'd0) begin
          cnt_d   = h_q - 6'd1;
          state_d = StSecond;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      StSecond: begin
        if (cnt_q == 6'd0) begin
          if (fill_q != '0) pop = 1'b1;
          else              state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (pop) begin
      bit_d   = mem_q[rd_ptr_q];
      h_d     = h_new;
      cnt_d   = h_new - 6'd1;
      state_d = StFirst;
    end
  end

  // FIFO bookkeeping; a pop frees a slot in the same cycle, so push-while-full-with-pop is kept.
  always_comb begin
    wr_en    = push & (~full | pop);
    ovf_d    = ovf_q | (push & full & ~pop);
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fill_d   = fill_q;
    if (wr_en && !pop)      fill_d = fill_q + 1'b1;
    else if (!wr_en && pop) fill_d = fill_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 6'd0;
      h_q      <= 6'd2;
      bit_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      h_q      <= h_d;
      bit_q    <= bit_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and fill.
  always_ff @(posedge clk) begin
    if (!rst_n && wr_en) mem_q[wr_ptr_q] <= push_bit;
  end

  always_comb begin
    out      = (state_q == StFirst) ? ~bit_q : ((state_q == StSecond) & bit_q);
    busy     = (state_q != StIdle) | (fill_q != '0);
    fill     = fill_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_led_chain_manchester_encoder.sv
module tb_led_chain_manchester_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_data, in_clk, in_forward, in_swap;
  logic [5:0] half_period;
  logic       out, busy, overflow;
  logic [3:0] fill;

  int checks = 0;
  int errors = 0;

  led_chain_manchester_encoder #(.DEPTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_clk      (in_clk),
    .in_forward  (in_forward),
    .in_swap     (in_swap),
    .half_period (half_period),
    .out         (out),
    .busy        (busy),
    .fill        (fill),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       c, f, d, s;
    logic [5:0] hp;
    logic       e_out, e_busy;
    logic [3:0] e_fill;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, input logic f, input logic d, input logic s,
                     input logic [5:0] hp, input logic eo, input logic eb,
                     input logic [3:0] ef, input logic eov);
    vec_t v;
    v.c = c; v.f = f; v.d = d; v.s = s; v.hp = hp;
    v.e_out = eo; v.e_busy = eb; v.e_fill = ef; v.e_ovf = eov;
    vecs.push_back(v);
  endtask

  task automatic rep(input int n, input logic [5:0] hp, input logic eo, input logic eb,
                     input logic [3:0] ef);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, 1'b0, hp, eo, eb, ef, 1'b0);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_clk = 1'b0; in_forward = 1'b0; in_data = 1'b0; in_swap = 1'b0;
  endtask

  logic [9:0] pat;
  int         s, off;

  initial begin
    idle_in();
    half_period = 6'd4;
    rst_n = 1'b1;
    step();
    step();
    chk("reset_state", {4'b0, out, busy, overflow, 1'b0}, 8'h00);
    chk("reset_fill", {4'b0, fill}, 8'h00);
    rst_n = 1'b0;

    // Single bit 1, H=4.
    add(1, 1, 1, 0, 6'd4, 0, 1, 4'd1, 0);
    rep(4, 6'd4, 0, 1, 4'd0);
    rep(4, 6'd4, 1, 1, 4'd0);
    rep(2, 6'd4, 0, 0, 4'd0);
    // Back-to-back 1,0,1 with H=3.
    add(1, 1, 1, 0, 6'd3, 0, 1, 4'd1, 0);
    add(1, 1, 0, 0, 6'd3, 0, 1, 4'd1, 0);
    add(1, 1, 1, 0, 6'd3, 0, 1, 4'd2, 0);
    rep(1, 6'd3, 0, 1, 4'd2);
    rep(3, 6'd3, 1, 1, 4'd2);
    rep(3, 6'd3, 1, 1, 4'd1);
    rep(3, 6'd3, 0, 1, 4'd1);
    rep(3, 6'd3, 0, 1, 4'd0);
    rep(3, 6'd3, 1, 1, 4'd0);
    rep(2, 6'd3, 0, 0, 4'd0);
    // Swapped 1 encodes as 0 (high then low), H=2.
    add(1, 1, 1, 1, 6'd2, 0, 1, 4'd1, 0);
    rep(2, 6'd2, 1, 1, 4'd0);
    rep(2, 6'd2, 0, 1, 4'd0);
    rep(1, 6'd2, 0, 0, 4'd0);
    // Strobes without forward are ignored.
    add(1, 0, 1, 0, 6'd2, 0, 0, 4'd0, 0);
    add(1, 0, 0, 1, 6'd2, 0, 0, 4'd0, 0);
    rep(2, 6'd2, 0, 0, 4'd0);
    // half_period=0 clamps to 2.
    add(1, 1, 1, 0, 6'd0, 0, 1, 4'd1, 0);
    rep(2, 6'd0, 0, 1, 4'd0);
    rep(2, 6'd0, 1, 1, 4'd0);
    rep(2, 6'd0, 0, 0, 4'd0);

    foreach (vecs[i]) begin
      in_clk = vecs[i].c; in_forward = vecs[i].f; in_data = vecs[i].d;
      in_swap = vecs[i].s; half_period = vecs[i].hp;
      step();
      chk($sformatf("vec%0d out/busy/fill/ovf", i),
          {1'b0, out, busy, fill, overflow},
          {1'b0, vecs[i].e_out, vecs[i].e_busy, vecs[i].e_fill, vecs[i].e_ovf});
    end
    idle_in();
    step();

    // Retiming: half_period 5 -> 8 during symbol 1; symbol 1 stays 10, symbol 2 is 16.
    half_period = 6'd5;
    in_clk = 1'b1; in_forward = 1'b1; in_data = 1'b1;
    step();                                   // edge 0
    in_data = 1'b0;
    step();                                   // edge 1: pop bit 1
    chk("retime e1", {7'b0, out}, 8'h00);
    idle_in();
    for (int e = 2; e <= 27; e++) begin
      if (e == 4) half_period = 6'd8;
      step();
      chk($sformatf("retime e%0d out", e), {7'b0, out},
          {7'b0, ((e >= 6 && e <= 10) || (e >= 11 && e <= 18))});
      if (e == 26 || e == 27) chk($sformatf("retime e%0d busy", e), {7'b0, busy},
                                  {7'b0, (e == 26)});
    end
    step();

    // Overflow: H=63, ten pushes; bit 0 popped, bits 1..8 stored, bit 9 dropped.
    half_period = 6'd63;
    pat = 10'b1101001101;
    for (int i = 0; i < 10; i++) begin
      in_clk = 1'b1; in_forward = 1'b1; in_data = pat[i];
      step();
    end
    idle_in();
    chk("ovf fill", {4'b0, fill}, 8'h08);
    chk("ovf flag", {7'b0, overflow}, 8'h01);
    for (int e = 10; e <= 1 + 126 * 9; e++) begin
      step();
      s = (e - 1) / 126;
      off = (e - 1) % 126;
      if (s < 9 && off == 30) chk($sformatf("ovf sym%0d first", s), {7'b0, out},
                                  {7'b0, ~pat[s]});
      if (s < 9 && off == 100) chk($sformatf("ovf sym%0d second", s), {7'b0, out},
                                   {7'b0, pat[s]});
    end
    chk("ovf drained out/busy", {6'b0, out, busy}, 8'h00);
    chk("ovf sticky", {7'b0, overflow}, 8'h01);

    // Reset in the middle of FIRST with fill=3; a push in the reset cycle is dropped.
    half_period = 6'd10;
    for (int i = 0; i < 4; i++) begin
      in_clk = 1'b1; in_forward = 1'b1; in_data = 1'b1;
      step();
    end
    chk("prerst fill", {4'b0, fill}, 8'h03);
    chk("prerst busy", {7'b0, busy}, 8'h01);
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    idle_in();
    chk("rst out/busy/ovf", {5'b0, out, busy, overflow}, 8'h00);
    chk("rst fill", {4'b0, fill}, 8'h00);
    for (int i = 0; i < 40; i++) begin
      step();
      chk($sformatf("postrst c%0d", i), {out, busy, 2'b0, fill}, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
